// File: rtl/obi_tlul_bridge_pkg.sv
// ----------------------------------------------------------------------------
// obi_tlul_bridge_pkg
// Shared types and helpers for the OBI -> TL-UL bridge:
//   - TL-UL channel structs (tl_h2d_t host->device, tl_d2h_t device->host)
//   - A/D channel opcode enums
//   - rob_entry_t: one reorder-buffer slot (valid, filled, we, addr, data, err)
//   - src_w(): slot-index width derived from the outstanding depth
//   - a_opcode_sel(): Get / PutFullData / PutPartialData selection
// ----------------------------------------------------------------------------
package obi_tlul_bridge_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_AIW = 8;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'h0,
        PUT_PARTIAL_DATA = 3'h1,
        GET              = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'h0,
        ACCESS_ACK_DATA = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [1:0]        a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [1:0]        d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    typedef struct packed {
        logic             valid;
        logic             filled;
        logic             we;
        logic [TL_AW-1:0] addr;
        logic [TL_DW-1:0] data;
        logic             err;
    } rob_entry_t;

    // A single-slot buffer still needs a one-bit index.
    function automatic int src_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic tl_a_op_e a_opcode_sel(input logic we, input logic [TL_DBW-1:0] be);
        if (!we) begin
            return GET;
        end
        return (be == {TL_DBW{1'b1}}) ? PUT_FULL_DATA : PUT_PARTIAL_DATA;
    endfunction

endpackage

// File: rtl/obi_tlul_rob.sv
// ----------------------------------------------------------------------------
// obi_tlul_rob
// Reorder buffer for the OBI -> TL-UL bridge. Slots are allocated in issue
// order at the tail; TL-UL responses fill slots out of order by source id;
// responses are released strictly in issue order from the head.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   alloc_*                 allocate the tail slot (we, addr)
//   alloc_slot_o            index of the slot the next allocation takes
//   free_o / busy_o         a slot is free / any slot outstanding
//   fill_*                  TL-UL D-channel beat (source, data, error)
//   rsp_*                   registered in-order response (valid pulse,
//                           data (0 for writes), error, original address)
// ----------------------------------------------------------------------------
module obi_tlul_rob
    import obi_tlul_bridge_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int SRC_W = src_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alloc_i,
    input  logic              alloc_we_i,
    input  logic [31:0]       alloc_addr_i,
    output logic [SRC_W-1:0]  alloc_slot_o,
    output logic              free_o,
    output logic              busy_o,
    input  logic              fill_valid_i,
    input  logic [TL_AIW-1:0] fill_source_i,
    input  logic [31:0]       fill_data_i,
    input  logic              fill_err_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic [31:0]       rsp_addr_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    rob_entry_t       slot_reg [DEPTH];
    logic [SRC_W-1:0] head_reg;
    logic [SRC_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             rsp_valid_reg;
    logic [31:0]      rsp_data_reg;
    logic             rsp_err_reg;
    logic [31:0]      rsp_addr_reg;

    logic [DEPTH-1:0] fill_hit;
    rob_entry_t       head_entry;
    logic             head_fill;
    logic             retire;
    logic             alloc;
    logic [31:0]      retire_data;
    logic             retire_err;

    function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] p);
        return (p == SRC_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A beat is accepted only for an allocated slot still waiting for its
    // response; stray or duplicate sources (including ones left over from
    // before a reset) fall through here unmatched.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fill
        assign fill_hit[gi] = fill_valid_i
                           && (fill_source_i == TL_AIW'(gi))
                           && slot_reg[gi].valid
                           && !slot_reg[gi].filled;
    end

    assign head_entry = slot_reg[head_reg];
    assign head_fill  = fill_hit[head_reg];

    // The head may retire in the same cycle its response arrives, so the
    // registered response shows up one cycle after d_valid.
    assign retire      = head_entry.valid && (head_entry.filled || head_fill);
    assign retire_data = head_entry.filled ? head_entry.data : fill_data_i;
    assign retire_err  = head_entry.filled ? head_entry.err  : fill_err_i;

    assign free_o       = (count_reg != CNT_W'(DEPTH));
    assign busy_o       = (count_reg != '0);
    assign alloc        = alloc_i && free_o;
    assign alloc_slot_o = tail_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= '0;
            end
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            rsp_addr_reg  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fill_hit[i]) begin
                    slot_reg[i].filled <= 1'b1;
                    slot_reg[i].data   <= fill_data_i;
                    slot_reg[i].err    <= fill_err_i;
                end
            end

            rsp_valid_reg <= retire;
            if (retire) begin
                rsp_data_reg              <= head_entry.we ? '0 : retire_data;
                rsp_err_reg               <= retire_err;
                rsp_addr_reg              <= head_entry.addr;
                slot_reg[head_reg].valid  <= 1'b0;
                slot_reg[head_reg].filled <= 1'b0;
                head_reg                  <= ptr_inc(head_reg);
            end

            // The tail slot is never the retiring head: they only coincide
            // when the buffer is full, and then nothing allocates.
            if (alloc) begin
                slot_reg[tail_reg].valid  <= 1'b1;
                slot_reg[tail_reg].filled <= 1'b0;
                slot_reg[tail_reg].we     <= alloc_we_i;
                slot_reg[tail_reg].addr   <= alloc_addr_i;
                slot_reg[tail_reg].data   <= '0;
                slot_reg[tail_reg].err    <= 1'b0;
                tail_reg                  <= ptr_inc(tail_reg);
            end

            case ({alloc, retire})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_data_o  = rsp_data_reg;
    assign rsp_err_o   = rsp_err_reg;
    assign rsp_addr_o  = rsp_addr_reg;

endmodule

// File: rtl/obi_tlul_bridge.sv
// ----------------------------------------------------------------------------
// obi_tlul_bridge
// Bridges an OBI host to a TL-UL device port with up to DEPTH outstanding
// transactions. Each granted request takes a reorder-buffer slot whose index
// is the TL-UL a_source; responses are returned to OBI in issue order.
// Parameters:
//   DEPTH     outstanding transactions (power of two, 1..16)
//   REQ_PIPE  1 = A channel driven from a one-entry skid register
// Ports:
//   clk_i, rst_i                                  clock, async active-high reset
//   obi_req_i/obi_gnt_o, obi_addr_i, obi_we_i,
//   obi_be_i, obi_wdata_i                         OBI request channel
//   obi_rvalid_o, obi_rdata_o, obi_err_o          OBI response channel
//   tl_o / tl_i                                   TL-UL host port
//   busy_o                                        transaction outstanding
//   err_o, err_addr_o                             sticky first-error capture
// Build option: define OBI_TLUL_BRIDGE_ERR_CAPTURE_EN to enable err_o /
// err_addr_o; otherwise both are tied to 0.
// ----------------------------------------------------------------------------
module obi_tlul_bridge
    import obi_tlul_bridge_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int REQ_PIPE = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        obi_req_i,
    output logic        obi_gnt_o,
    input  logic [31:0] obi_addr_i,
    input  logic        obi_we_i,
    input  logic [3:0]  obi_be_i,
    input  logic [31:0] obi_wdata_i,
    output logic        obi_rvalid_o,
    output logic [31:0] obi_rdata_o,
    output logic        obi_err_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    localparam int SRC_W = src_w(DEPTH);

    logic             slot_free;
    logic             rob_busy;
    logic             skid_busy;
    logic             alloc;
    logic [SRC_W-1:0] alloc_slot;
    logic             rsp_valid;
    logic             rsp_err;
    logic [31:0]      rsp_addr;
    tl_h2d_t          a_req;
    tl_h2d_t          a_chan;

    // A-channel beat built straight from the OBI request and the slot it
    // would be given if granted this cycle.
    always_comb begin
        a_req           = '0;
        a_req.a_valid   = 1'b1;
        a_req.a_opcode  = a_opcode_sel(obi_we_i, obi_be_i);
        a_req.a_size    = 2'd2;
        a_req.a_source  = TL_AIW'(alloc_slot);
        a_req.a_address = {obi_addr_i[31:2], 2'b00};
        a_req.a_mask    = obi_we_i ? obi_be_i : 4'hF;
        a_req.a_data    = obi_we_i ? obi_wdata_i : '0;
        a_req.d_ready   = 1'b1;
    end

    if (REQ_PIPE != 0) begin : g_skid
        tl_h2d_t skid_reg;

        // Accept while the skid is empty or is being drained this cycle.
        assign alloc = obi_req_i && slot_free && (!skid_reg.a_valid || tl_i.a_ready);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                skid_reg <= '0;
            end else if (alloc) begin
                skid_reg <= a_req;
            end else if (tl_i.a_ready) begin
                skid_reg.a_valid <= 1'b0;
            end
        end

        assign a_chan    = skid_reg;
        assign skid_busy = skid_reg.a_valid;
    end else begin : g_direct
        assign alloc = obi_req_i && slot_free && tl_i.a_ready;

        always_comb begin
            a_chan         = a_req;
            a_chan.a_valid = obi_req_i && slot_free;
        end

        assign skid_busy = 1'b0;
    end

    always_comb begin
        tl_o         = a_chan;
        tl_o.d_ready = 1'b1;
    end

    assign obi_gnt_o    = alloc;
    assign busy_o       = rob_busy || skid_busy;
    assign obi_rvalid_o = rsp_valid;
    assign obi_err_o    = rsp_err;

    obi_tlul_rob #(
        .DEPTH (DEPTH)
    ) u_rob (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .alloc_i       (alloc),
        .alloc_we_i    (obi_we_i),
        .alloc_addr_i  (obi_addr_i),
        .alloc_slot_o  (alloc_slot),
        .free_o        (slot_free),
        .busy_o        (rob_busy),
        .fill_valid_i  (tl_i.d_valid),
        .fill_source_i (tl_i.d_source),
        .fill_data_i   (tl_i.d_data),
        .fill_err_i    (tl_i.d_error),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (obi_rdata_o),
        .rsp_err_o     (rsp_err),
        .rsp_addr_o    (rsp_addr)
    );

`ifdef OBI_TLUL_BRIDGE_ERR_CAPTURE_EN
    logic        err_reg;
    logic [31:0] err_addr_reg;

    // Only the first erroring response since reset is recorded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_reg      <= 1'b0;
            err_addr_reg <= '0;
        end else if (rsp_valid && rsp_err && !err_reg) begin
            err_reg      <= 1'b1;
            err_addr_reg <= rsp_addr;
        end
    end

    assign err_o      = err_reg;
    assign err_addr_o = err_addr_reg;
`else
    logic unused_rsp_addr;
    assign unused_rsp_addr = ^rsp_addr;
    assign err_o           = 1'b0;
    assign err_addr_o      = '0;
`endif

    // D-channel fields the bridge has no use for.
    logic unused_tl;
    assign unused_tl = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_sink};

endmodule

// File: doc/obi_tlul_bridge.md
OBI_TLUL_BRIDGE -- requirements
Module: obi_tlul_bridge

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding transactions (power of two, 1..16).
REQ-002 SHALL have parameter REQ_PIPE, default 0, 1 = register the TL-UL A channel (skid stage).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk_i  in  1  clock.
REQ-005 SHALL have port rst_i  in  1  asynchronous active-high reset.
REQ-006 SHALL have port obi_req_i  in  1  OBI request.
REQ-007 SHALL have port obi_gnt_o  out  1  OBI grant.
REQ-008 SHALL have ports obi_addr_i in 32, obi_we_i in 1, obi_be_i in 4, obi_wdata_i in 32  OBI request payload.
REQ-009 SHALL have ports obi_rvalid_o out 1, obi_rdata_o out 32, obi_err_o out 1  OBI response.
REQ-010 SHALL have ports tl_o  out  tl_h2d_t, tl_i  in  tl_d2h_t  TL-UL host port.
REQ-011 SHALL have port busy_o  out  1  any transaction outstanding.
REQ-012 SHALL have ports err_o out 1, err_addr_o out 32  sticky error capture.

Function
REQ-013 SHALL allocate a free slot per granted request; a_source = slot index, zero-extended.
REQ-014 SHALL drive a_opcode Get for reads, PutFullData for writes with be==4'hF, PutPartialData otherwise.
REQ-015 SHALL drive a_size=2, a_address={addr[31:2],2'b00}, a_mask=be for writes, 4'hF for reads.
REQ-016 SHALL assert obi_gnt_o only when obi_req_i, a slot is free, and (REQ_PIPE=0: a_ready; REQ_PIPE=1: skid stage empty or draining this cycle).
REQ-017 SHALL hold obi_gnt_o low while outstanding count == DEPTH.
REQ-018 SHALL drive d_ready constantly 1; on d_valid store d_data and d_error into the slot given by d_source.
REQ-019 SHALL ignore d_valid whose d_source is not an allocated, unfilled slot.
REQ-020 SHALL return responses strictly in issue order: obi_rvalid_o pulses one cycle when the head slot is filled, then head advances.
REQ-021 SHALL register obi_rvalid_o: earliest response one cycle after the matching d_valid.
REQ-022 SHALL drive obi_rdata_o 0 for write responses and obi_err_o = stored d_error.
REQ-023 SHALL keep count unchanged on simultaneous allocate and retire; pointers wrap modulo DEPTH.
REQ-024 SHALL drive busy_o = (count != 0) or skid stage occupied.

Reset
REQ-025 SHALL reset all outputs, a_valid, count, pointers, slot valid bits, err_o, err_addr_o to 0.
REQ-026 SHALL discard all outstanding transactions on reset; later responses to them are ignored per REQ-019.

Configuration
REQ-027 SHALL honour macro OBI_TLUL_BRIDGE_ERR_CAPTURE_EN.
REQ-028 SHALL, with the macro defined, set err_o sticky and latch the address of the first erroring transaction into err_addr_o until reset.
REQ-029 SHALL, without the macro, tie err_o and err_addr_o to 0; obi_err_o unaffected.

Structure
REQ-030 SHALL place rob_entry_t (valid, filled, we, addr, data, err), the opcode-select function and SRC_W derivation in package obi_tlul_bridge_pkg.
REQ-031 SHALL implement the reorder buffer as sub-module obi_tlul_rob.

Verification
REQ-032 SHALL cover read: addr 0x1000_0004 -> a_opcode Get, a_address 0x1000_0004, mask F; d_data 0xDEAD_BEEF -> obi_rdata_o 0xDEAD_BEEF one cycle later.
REQ-033 SHALL cover write be=4'b0011, wdata 0x1234_5678 -> PutPartialData, mask 3; be=4'hF -> PutFullData.
REQ-034 SHALL cover DEPTH=4, 4 reads issued, responses returned source 3,1,0,2 -> obi_rvalid_o in order 0,1,2,3; fifth request not granted until slot 0 retires.
REQ-035 SHALL cover d_error=1 on read to 0x2000_0010 -> obi_err_o=1; with macro err_o=1, err_addr_o=0x2000_0010, second error leaves it unchanged; without macro both 0.
REQ-036 SHALL cover rst_i asserted with 2 outstanding -> busy_o=0 next cycle, late d_valid produces no obi_rvalid_o.
REQ-037 SHALL cover REQ_PIPE=1 with a_ready held low 5 cycles -> one request accepted into skid, further gnt low, tl_o payload stable.
